digest_readout: RTL and testbench
=================================

Name: digest_readout

Overview:
- Consumer end of the SHA-256 hash-state accumulators (H0..H7).
- Captures the eight 32-bit accumulated words when the final block of a message completes.
- Holds them in a shadow register, then streams them out one word per handshake on a valid/ready interface, H0 first, toward the nonce checker / host link.
- Frees the accumulators to start the next nonce immediately after capture.

Parameters:
- WORDS, 8, number of hash words per digest.
- WIDTH, 32, bits per hash word.
- BYTE_SWAP, 0, 1 = reverse byte order within each output word (little-endian digest presentation).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digest_valid  input  1  one-cycle strobe: digest_in holds a completed digest.
- digest_in  input  WORDS*WIDTH  concatenated H0..H7; H0 in the MSBs.
- digest_ready  output  1  block can accept a digest this cycle.
- out_data  output  WIDTH  current hash word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_last  output  1  out_data is the final word (H7).
- busy  output  1  digest held and not fully sent.
- overrun  output  1  sticky: a digest_valid was dropped.
- clear_overrun  input  1  clears overrun.

Behaviour:
- Interface: one clock, clk; reset asynchronous active-low, rst_n. Reset forces:
  - state IDLE;
  - shadow register, word index, overrun all 0;
  - out_valid, out_last, busy 0;
  - out_data 0;
  - digest_ready 1.
- Reset mid-stream aborts the transfer immediately; no partial word is re-sent after release.
- States:
  - IDLE: digest_ready=1, out_valid=0. On digest_valid, capture digest_in into the shadow register, set index=0, go to SEND.
  - SEND: out_valid=1, busy=1, out_data=shadow word[index] (optionally byte-swapped), out_last=(index==WORDS-1).
- Handshake: a word transfers when out_valid && out_ready.
  - index<WORDS-1: index increments.
  - index==WORDS-1: return to IDLE.
- out_data, out_valid and out_last are driven only from registers and stay stable while out_valid && !out_ready.
- Latency: digest_valid in cycle N gives out_valid=1 with H0 in cycle N+1. Minimum WORDS cycles per digest with out_ready held high.
- Back-to-back: digest_ready is also 1 in SEND when index==WORDS-1 && out_ready (a combinational path from out_ready).
  - digest_valid in that cycle is accepted: the new digest is captured, index=0, state stays SEND.
  - The next cycle presents the new H0 with no bubble.
- Drop rule: digest_valid while digest_ready=0 is ignored. The shadow register is unchanged, overrun is set, and the in-flight transfer continues unaffected.
- clear_overrun clears overrun next cycle; if a set and a clear occur in the same cycle, the set wins.
- Byte swap: with BYTE_SWAP=1, out_data = {w[7:0], w[15:8], w[23:16], w[31:24]} of the selected word. Applied at output only; the shadow register stores words unchanged.
- No arithmetic on the data path; index width is clog2(WORDS) and never wraps past WORDS-1.

Decomposition:
- sha256_pkg holds:
  - SHA256_WORDS=8 and SHA256_WIDTH=32;
  - the H_INIT constants 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19;
  - the state enum {IDLE, SEND};
  - a bswap32 function.
- No sub-module: the FSM, shadow register and output mux fit in one module.

Test Plan:
- Capture and stream: rst_n low 3 cycles then high. digest_in = H_INIT concatenation, digest_valid 1 cycle, out_ready=1 -> 8 consecutive words 6a09e667 … 5be0cd19 starting the next cycle; out_last only with 5be0cd19; then digest_ready=1, busy=0.
- Backpressure: same digest, out_ready toggles 1,0,0,1,… -> each word held stable while stalled; order preserved; no duplicate or skipped words.
- Back-to-back: second digest (SHA-256 "abc": ba7816bf … f20015ad) strobed in the cycle H7 handshakes -> ba7816bf appears the next cycle with no gap; overrun stays 0.
- Overrun: digest_valid pulsed while index=3 -> stream completes with the original words; overrun=1. clear_overrun pulse -> overrun=0. A set and a clear in the same cycle -> overrun=1.
- Byte swap: BYTE_SWAP=1, first word 6a09e667 -> out_data=67e6096a.
- Reset mid-stream: rst_n low during word 5 -> out_valid=0 asynchronously. After release, out_valid stays 0 until a new digest_valid, then the new stream starts at H0.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 hash-state constants, FSM state type and byte-swap helper.
package sha256_pkg;

  localparam int SHA256_WORDS = 8;
  localparam int SHA256_WIDTH = 32;

  // Initial hash values H0..H7, H0 in the MSBs.
  localparam logic [SHA256_WORDS*SHA256_WIDTH-1:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/digest_readout.sv
// rtl/digest_readout.sv - captures a completed SHA-256 digest into a shadow register and streams it out word by word.
module digest_readout
  import sha256_pkg::*;
#(
  parameter int WORDS     = SHA256_WORDS,
  parameter int WIDTH     = SHA256_WIDTH,
  parameter int BYTE_SWAP = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   digest_valid,
  input  logic [WORDS*WIDTH-1:0] digest_in,
  output logic                   digest_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   clear_overrun
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t           state;
  logic [WIDTH-1:0] shadow [WORDS];
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nxt;
  logic             on_last;
  logic             xfer;
  logic             accept;
  logic             drop;

  // Byte reversal is applied only on the way out; the shadow keeps words as captured.
  function automatic logic [WIDTH-1:0] present(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (BYTE_SWAP != 0) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        r[b*8 +: 8] = w[WIDTH-8-b*8 +: 8];
      end
    end
    return r;
  endfunction

  assign idx_nxt = idx + 1'b1;
  assign on_last = (state == SEND) && (idx == LAST_IDX);
  assign xfer    = out_valid && out_ready;

  // Ready while the final word handshakes so a new digest follows with no bubble.
  assign digest_ready = (state == IDLE) || (on_last && out_ready);
  assign accept       = digest_valid && digest_ready;
  assign drop         = digest_valid && !digest_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < WORDS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end

      if (accept) begin
        for (int i = 0; i < WORDS; i++) begin
          shadow[i] <= digest_in[(WORDS-1-i)*WIDTH +: WIDTH];
        end
        idx       <= '0;
        state     <= SEND;
        out_valid <= 1'b1;
        busy      <= 1'b1;
        out_last  <= (WORDS == 1);
        out_data  <= present(digest_in[WORDS*WIDTH-1 -: WIDTH]);
      end else if (xfer) begin
        if (idx == LAST_IDX) begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_last  <= 1'b0;
          out_data  <= '0;
        end else begin
          idx      <= idx_nxt;
          out_data <= present(shadow[idx_nxt]);
          out_last <= (idx_nxt == LAST_IDX);
        end
      end
    end
  end

endmodule

// File: tb/tb_digest_readout.sv
// tb/tb_digest_readout.sv - directed self-checking bench for digest_readout.
module tb_digest_readout;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         digest_valid;
  logic [255:0] digest_in;
  logic         digest_ready, digest_ready_sw;
  logic [31:0]  out_data, out_data_sw;
  logic         out_valid, out_valid_sw;
  logic         out_ready;
  logic         out_last, out_last_sw;
  logic         busy, busy_sw;
  logic         overrun, overrun_sw;
  logic         clear_overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] h_exp [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] abc_exp [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [255:0] abc_digest = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                              32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  always #5 clk = ~clk;

  digest_readout #(.WORDS(8), .WIDTH(32), .BYTE_SWAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest_in(digest_in),
    .digest_ready(digest_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  digest_readout #(.WORDS(8), .WIDTH(32), .BYTE_SWAP(1)) dut_sw (
    .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest_in(digest_in),
    .digest_ready(digest_ready_sw), .out_data(out_data_sw), .out_valid(out_valid_sw),
    .out_ready(out_ready), .out_last(out_last_sw), .busy(busy_sw), .overrun(overrun_sw),
    .clear_overrun(clear_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns in the cycle that presents H0.
  task automatic strobe(input logic [255:0] d);
    digest_in    = d;
    digest_valid = 1'b1;
    tick();
    digest_valid = 1'b0;
  endtask

  task automatic expect_words(input string tag, input logic [31:0] exp [8], input int from);
    for (int i = from; i < 8; i++) begin
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, out_data, exp[i]);
      check({tag, "_last"}, 32'(out_last), 32'(i == 7));
      tick();
    end
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_ready"}, 32'(digest_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c;
    rst_n         = 1'b0;
    digest_valid  = 1'b0;
    digest_in     = '0;
    out_ready     = 1'b1;
    clear_overrun = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_ready", 32'(digest_ready), 32'd1);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Capture and stream, with byte-swapped view from the second instance
    digest_in    = H_INIT;
    digest_valid = 1'b1;
    @(negedge clk);
    check("lat_valid_before", 32'(out_valid), 32'd0);
    tick();
    digest_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("cap_valid", 32'(out_valid), 32'd1);
      check("cap_data", out_data, h_exp[i]);
      check("cap_last", 32'(out_last), 32'(i == 7));
      if (i == 0) check("swap_w0", out_data_sw, 32'h67e6096a);
      if (i == 1) check("swap_w1", out_data_sw, 32'h85ae67bb);
      if (i == 3) begin
        check("cap_busy", 32'(busy), 32'd1);
        check("cap_ready_mid", 32'(digest_ready), 32'd0);
      end
      tick();
    end
    expect_idle("cap");

    // Backpressure: out_ready pattern 1,0,0,1 repeating
    tick();
    strobe(H_INIT);
    k = 0;
    c = 0;
    while (k < 8 && c < 64) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, h_exp[k]);
      check("bp_last", 32'(out_last), 32'(k == 7));
      if (out_ready) k++;
      tick();
      c++;
    end
    check("bp_count", 32'(k), 32'd8);
    out_ready = 1'b1;
    expect_idle("bp");

    // Back-to-back: next digest strobed while H7 handshakes
    tick();
    strobe(H_INIT);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("b2b_first_data", out_data, h_exp[i]);
      tick();
    end
    digest_in    = abc_digest;
    digest_valid = 1'b1;
    @(negedge clk);
    check("b2b_h7", out_data, h_exp[7]);
    check("b2b_ready", 32'(digest_ready), 32'd1);
    tick();
    digest_valid = 1'b0;
    expect_words("b2b_abc", abc_exp, 0);
    check("b2b_overrun", 32'(overrun), 32'd0);
    expect_idle("b2b");

    // Overrun: digest dropped while word 3 is on the bus
    tick();
    strobe(H_INIT);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovr_data", out_data, h_exp[i]);
      tick();
    end
    digest_in    = abc_digest;
    digest_valid = 1'b1;
    @(negedge clk);
    check("ovr_ready_busy", 32'(digest_ready), 32'd0);
    check("ovr_data3", out_data, h_exp[3]);
    tick();
    digest_valid = 1'b0;
    expect_words("ovr_rest", h_exp, 4);
    @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    tick();
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    @(negedge clk);
    check("ovr_clear", 32'(overrun), 32'd0);
    tick();

    // Set and clear in the same cycle: set wins
    strobe(H_INIT);
    tick();
    tick();
    digest_in     = abc_digest;
    digest_valid  = 1'b1;
    clear_overrun = 1'b1;
    tick();
    digest_valid  = 1'b0;
    clear_overrun = 1'b0;
    expect_words("ovr_both", h_exp, 3);
    check("ovr_set_wins", 32'(overrun), 32'd1);

    // Reset mid-stream during word 5
    tick();
    strobe(H_INIT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rms_data", out_data, h_exp[i]);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rms_async_valid", 32'(out_valid), 32'd0);
    check("rms_async_busy", 32'(busy), 32'd0);
    check("rms_async_ovr", 32'(overrun), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rms_quiet", 32'(out_valid), 32'd0);
      tick();
    end
    strobe(abc_digest);
    expect_words("rms_new", abc_exp, 0);
    expect_idle("rms");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
